// File: rtl/lq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lq_pkg
// Brief    : Shared types and width constants for the load queue.
// Revision : 1.0
// ============================================================================
package lq_pkg;

   localparam int LQ_ADDR_W    = 32;
   localparam int LQ_DATA_W    = 32;
   // Stored tag width; covers any ROB_DEPTH up to 256 and is sliced at the ports
   localparam int LQ_TAG_MAX_W = 8;

   typedef enum logic [1:0] {
      LQ_FREE   = 2'd0,
      LQ_WAIT   = 2'd1,
      LQ_ISSUED = 2'd2
   } lq_state_e;

   typedef struct packed {
      lq_state_e               state;
      logic [LQ_ADDR_W-1:0]    addr;
      logic [LQ_TAG_MAX_W-1:0] rob_ix;
   } lq_entry_t;

   localparam lq_entry_t LQ_ENTRY_RESET = '{state: LQ_FREE, addr: '0, rob_ix: '0};

endpackage
`default_nettype wire

// File: rtl/load_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : load_queue_if
// Brief    : Alloc, memory request/response, writeback and ROB export bundle.
// Revision : 1.0
// ============================================================================
interface load_queue_if #(
   parameter int LQ_DEPTH  = 4,
   parameter int ROB_DEPTH = 8
);
   import lq_pkg::*;

   localparam int ROB_IX_W = $clog2(ROB_DEPTH);
   localparam int CNT_W    = $clog2(LQ_DEPTH + 1);

   logic                          flush_in;
   logic                          alloc_valid_in;
   logic [LQ_ADDR_W-1:0]          alloc_addr_in;
   logic [ROB_IX_W-1:0]           alloc_rob_ix_in;
   logic                          alloc_ready_out;
   logic [ROB_DEPTH-1:0]          can_load_mask_in;
   logic                          mem_req_valid_out;
   logic                          mem_req_ready_in;
   logic [LQ_ADDR_W-1:0]          mem_req_addr_out;
   logic [ROB_IX_W-1:0]           mem_req_rob_ix_out;
   logic                          mem_resp_valid_in;
   logic [ROB_IX_W-1:0]           mem_resp_rob_ix_in;
   logic [LQ_DATA_W-1:0]          mem_resp_data_in;
   logic                          wb_valid_out;
   logic [ROB_IX_W-1:0]           wb_rob_ix_out;
   logic [LQ_DATA_W-1:0]          wb_data_out;
   logic [LQ_ADDR_W*LQ_DEPTH-1:0] lq_addr_flat_out;
   logic [ROB_IX_W*LQ_DEPTH-1:0]  lq_rob_ix_flat_out;
   logic [LQ_DEPTH-1:0]           lq_valid_flat_out;
   logic [CNT_W-1:0]              occupancy_out;

   modport master (
      output flush_in, alloc_valid_in, alloc_addr_in, alloc_rob_ix_in,
             can_load_mask_in, mem_req_ready_in,
             mem_resp_valid_in, mem_resp_rob_ix_in, mem_resp_data_in,
      input  alloc_ready_out, mem_req_valid_out, mem_req_addr_out, mem_req_rob_ix_out,
             wb_valid_out, wb_rob_ix_out, wb_data_out,
             lq_addr_flat_out, lq_rob_ix_flat_out, lq_valid_flat_out, occupancy_out
   );

   modport slave (
      input  flush_in, alloc_valid_in, alloc_addr_in, alloc_rob_ix_in,
             can_load_mask_in, mem_req_ready_in,
             mem_resp_valid_in, mem_resp_rob_ix_in, mem_resp_data_in,
      output alloc_ready_out, mem_req_valid_out, mem_req_addr_out, mem_req_rob_ix_out,
             wb_valid_out, wb_rob_ix_out, wb_data_out,
             lq_addr_flat_out, lq_rob_ix_flat_out, lq_valid_flat_out, occupancy_out
   );

endinterface
`default_nettype wire

// File: rtl/lq_age_matrix.sv
`default_nettype none
// ============================================================================
// Module   : lq_age_matrix
// Brief    : Allocation-order age matrix; picks the oldest eligible entry.
//            Only built when LQ_OLDEST_FIRST_EN is defined.
// Revision : 1.0
// ============================================================================
`ifdef LQ_OLDEST_FIRST_EN
module lq_age_matrix #(
   parameter int LQ_DEPTH = 4
) (
   input  wire logic                clk_in,
   input  wire logic                rst_in,
   input  wire logic [LQ_DEPTH-1:0] alloc_oh_in,
   input  wire logic [LQ_DEPTH-1:0] eligible_in,
   output logic      [LQ_DEPTH-1:0] oldest_oh_out
);

   // older_q[i][j] set: entry i was allocated before entry j
   logic [LQ_DEPTH-1:0] older_q [LQ_DEPTH];
   logic [LQ_DEPTH-1:0] older_d [LQ_DEPTH];

   always_comb begin : p_next
      older_d = older_q;
      for (int k = 0; k < LQ_DEPTH; k++) begin
         if (alloc_oh_in[k]) begin
            older_d[k] = '0;
            for (int j = 0; j < LQ_DEPTH; j++) begin
               if (j != k) older_d[j][k] = 1'b1;
            end
         end
      end
   end

   always_comb begin : p_oldest
      oldest_oh_out = '0;
      for (int i = 0; i < LQ_DEPTH; i++) begin
         logic blocked;
         blocked = 1'b0;
         for (int j = 0; j < LQ_DEPTH; j++) begin
            if (eligible_in[j] && older_q[j][i]) blocked = 1'b1;
         end
         oldest_oh_out[i] = eligible_in[i] && !blocked;
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin : p_regs
      if (rst_in) begin
         for (int i = 0; i < LQ_DEPTH; i++) older_q[i] <= '0;
      end else begin
         older_q <= older_d;
      end
   end

endmodule
`endif
`default_nettype wire

// File: rtl/load_queue.sv
`default_nettype none
// ============================================================================
// Module   : load_queue
// Brief    : Tagged load queue: alloc, issue when the ROB allows, writeback.
//            Define LQ_OLDEST_FIRST_EN for oldest-first issue selection.
// Revision : 1.0
// ============================================================================
module load_queue
   import lq_pkg::*;
#(
   parameter int LQ_DEPTH  = 4,
   parameter int ROB_DEPTH = 8
) (
   input wire logic  clk_in,
   input wire logic  rst_in,
   load_queue_if.slave bus
);

   localparam int ROB_IX_W = $clog2(ROB_DEPTH);
   localparam int CNT_W    = $clog2(LQ_DEPTH + 1);

   lq_entry_t            entries_q [LQ_DEPTH];
   lq_entry_t            entries_d [LQ_DEPTH];
   logic                 wb_valid_q, wb_valid_d;
   logic [ROB_IX_W-1:0]  wb_rob_ix_q, wb_rob_ix_d;
   logic [LQ_DATA_W-1:0] wb_data_q, wb_data_d;

   logic [LQ_DEPTH-1:0]  free_vec, eligible_vec, resp_oh, alloc_oh, sel_oh, issue_oh;
   logic [LQ_ADDR_W-1:0] req_addr;
   logic [ROB_IX_W-1:0]  req_rob_ix;
   logic [CNT_W-1:0]     occ;

   function automatic logic [LQ_DEPTH-1:0] lowest_oh(input logic [LQ_DEPTH-1:0] v);
      return v & (~v + LQ_DEPTH'(1));
   endfunction

   always_comb begin : p_decode
      free_vec     = '0;
      eligible_vec = '0;
      resp_oh      = '0;
      for (int i = 0; i < LQ_DEPTH; i++) begin
         free_vec[i] = (entries_q[i].state == LQ_FREE);
         // Mask is indexed by ROB tag, not by queue row
         for (int r = 0; r < ROB_DEPTH; r++) begin
            if (entries_q[i].state == LQ_WAIT && entries_q[i].rob_ix == LQ_TAG_MAX_W'(r)
                && bus.can_load_mask_in[r])
               eligible_vec[i] = 1'b1;
         end
         resp_oh[i] = bus.mem_resp_valid_in && (entries_q[i].state == LQ_ISSUED)
                      && (entries_q[i].rob_ix == LQ_TAG_MAX_W'(bus.mem_resp_rob_ix_in));
      end
   end

   assign alloc_oh = (bus.alloc_valid_in && !bus.flush_in) ? lowest_oh(free_vec) : '0;

`ifdef LQ_OLDEST_FIRST_EN
   lq_age_matrix #(.LQ_DEPTH(LQ_DEPTH)) u_age (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .alloc_oh_in   (alloc_oh),
      .eligible_in   (eligible_vec),
      .oldest_oh_out (sel_oh)
   );
`else
   assign sel_oh = lowest_oh(eligible_vec);
`endif

   assign issue_oh = bus.mem_req_ready_in ? sel_oh : '0;

   always_comb begin : p_outputs
      req_addr               = '0;
      req_rob_ix             = '0;
      occ                    = '0;
      bus.lq_addr_flat_out   = '0;
      bus.lq_rob_ix_flat_out = '0;
      for (int i = 0; i < LQ_DEPTH; i++) begin
         if (sel_oh[i]) begin
            req_addr   = req_addr | entries_q[i].addr;
            req_rob_ix = req_rob_ix | entries_q[i].rob_ix[ROB_IX_W-1:0];
         end
         occ = occ + CNT_W'(!free_vec[i]);
         bus.lq_addr_flat_out[LQ_ADDR_W*i +: LQ_ADDR_W] = entries_q[i].addr;
         bus.lq_rob_ix_flat_out[ROB_IX_W*i +: ROB_IX_W] = entries_q[i].rob_ix[ROB_IX_W-1:0];
      end
   end

   assign bus.alloc_ready_out    = |free_vec;
   assign bus.mem_req_valid_out  = |eligible_vec;
   assign bus.mem_req_addr_out   = req_addr;
   assign bus.mem_req_rob_ix_out = req_rob_ix;
   assign bus.lq_valid_flat_out  = ~free_vec;
   assign bus.occupancy_out      = occ;
   assign bus.wb_valid_out       = wb_valid_q;
   assign bus.wb_rob_ix_out      = wb_rob_ix_q;
   assign bus.wb_data_out        = wb_data_q;

   always_comb begin : p_next
      entries_d   = entries_q;
      wb_valid_d  = 1'b0;
      wb_rob_ix_d = wb_rob_ix_q;
      wb_data_d   = wb_data_q;
      if (bus.flush_in) begin
         for (int i = 0; i < LQ_DEPTH; i++) entries_d[i] = LQ_ENTRY_RESET;
      end else begin
         // Response, issue and alloc always target distinct rows
         for (int i = 0; i < LQ_DEPTH; i++) begin
            if (resp_oh[i])  entries_d[i] = LQ_ENTRY_RESET;
            if (issue_oh[i]) entries_d[i].state = LQ_ISSUED;
            if (alloc_oh[i])
               entries_d[i] = '{state:  LQ_WAIT,
                                addr:   bus.alloc_addr_in,
                                rob_ix: LQ_TAG_MAX_W'(bus.alloc_rob_ix_in)};
         end
         if (|resp_oh) begin
            wb_valid_d  = 1'b1;
            wb_rob_ix_d = bus.mem_resp_rob_ix_in;
            wb_data_d   = bus.mem_resp_data_in;
         end
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin : p_regs
      if (rst_in) begin
         for (int i = 0; i < LQ_DEPTH; i++) entries_q[i] <= LQ_ENTRY_RESET;
         wb_valid_q  <= 1'b0;
         wb_rob_ix_q <= '0;
         wb_data_q   <= '0;
      end else begin
         entries_q   <= entries_d;
         wb_valid_q  <= wb_valid_d;
         wb_rob_ix_q <= wb_rob_ix_d;
         wb_data_q   <= wb_data_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_load_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_queue
// Brief    : Directed bench for load_queue with a queue-level reference model.
// Revision : 1.0
// ============================================================================
module tb_load_queue;

   localparam int LQ_DEPTH  = 4;
   localparam int ROB_DEPTH = 8;
   localparam int ROB_IX_W  = 3;
   localparam int M_FREE    = 0;
   localparam int M_WAIT    = 1;
   localparam int M_ISSUED  = 2;

   logic clk_in = 1'b0;
   logic rst_in = 1'b1;
   always #5 clk_in = ~clk_in;

   load_queue_if #(.LQ_DEPTH(LQ_DEPTH), .ROB_DEPTH(ROB_DEPTH)) bus ();

   load_queue #(.LQ_DEPTH(LQ_DEPTH), .ROB_DEPTH(ROB_DEPTH)) dut (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .bus    (bus.slave)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: entry list with allocation sequence numbers
   int          m_state [LQ_DEPTH];
   logic [31:0] m_addr  [LQ_DEPTH];
   int          m_tag   [LQ_DEPTH];
   int          m_age   [LQ_DEPTH];
   int          m_seq;
   logic        m_wb_v;
   int          m_wb_tag;
   logic [31:0] m_wb_data;

   function automatic int m_pick();
      int best = -1;
      for (int i = 0; i < LQ_DEPTH; i++) begin
         if (m_state[i] == M_WAIT && bus.can_load_mask_in[m_tag[i]]) begin
`ifdef LQ_OLDEST_FIRST_EN
            if (best < 0 || m_age[i] < m_age[best]) best = i;
`else
            if (best < 0) best = i;
`endif
         end
      end
      return best;
   endfunction

   function automatic int m_first_free();
      for (int i = 0; i < LQ_DEPTH; i++) if (m_state[i] == M_FREE) return i;
      return -1;
   endfunction

   always @(posedge clk_in or posedge rst_in) begin
      int a, s, r;
      if (rst_in) begin
         for (int i = 0; i < LQ_DEPTH; i++) begin
            m_state[i] = M_FREE; m_addr[i] = 0; m_tag[i] = 0; m_age[i] = 0;
         end
         m_seq = 0; m_wb_v = 1'b0; m_wb_tag = 0; m_wb_data = 0;
      end else begin
         a = m_first_free();
         s = m_pick();
         r = -1;
         if (bus.mem_resp_valid_in)
            for (int i = 0; i < LQ_DEPTH; i++)
               if (m_state[i] == M_ISSUED && m_tag[i] == int'(bus.mem_resp_rob_ix_in)) r = i;
         if (bus.flush_in) begin
            for (int i = 0; i < LQ_DEPTH; i++) m_state[i] = M_FREE;
            m_wb_v = 1'b0;
         end else begin
            m_wb_v = (r >= 0);
            if (r >= 0) begin
               m_wb_tag  = m_tag[r];
               m_wb_data = bus.mem_resp_data_in;
               m_state[r] = M_FREE;
            end
            if (s >= 0 && bus.mem_req_ready_in) m_state[s] = M_ISSUED;
            if (a >= 0 && bus.alloc_valid_in) begin
               m_state[a] = M_WAIT;
               m_addr[a]  = bus.alloc_addr_in;
               m_tag[a]   = int'(bus.alloc_rob_ix_in);
               m_age[a]   = m_seq;
               m_seq++;
            end
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge
   always @(negedge clk_in) begin
      int n, s;
      if (!rst_in) begin
         n = 0;
         for (int i = 0; i < LQ_DEPTH; i++) if (m_state[i] != M_FREE) n++;
         chk("occupancy", 32'(bus.occupancy_out), n);
         chk("alloc_ready", 32'(bus.alloc_ready_out), 32'(n < LQ_DEPTH));
         for (int i = 0; i < LQ_DEPTH; i++) begin
            chk("valid_flat", 32'(bus.lq_valid_flat_out[i]), 32'(m_state[i] != M_FREE));
            if (m_state[i] != M_FREE) begin
               chk("addr_flat", bus.lq_addr_flat_out[32*i +: 32], m_addr[i]);
               chk("tag_flat", 32'(bus.lq_rob_ix_flat_out[ROB_IX_W*i +: ROB_IX_W]), m_tag[i]);
            end
         end
         s = m_pick();
         chk("req_valid", 32'(bus.mem_req_valid_out), 32'(s >= 0));
         if (s >= 0) begin
            chk("req_addr", bus.mem_req_addr_out, m_addr[s]);
            chk("req_tag", 32'(bus.mem_req_rob_ix_out), m_tag[s]);
         end
         chk("wb_valid", 32'(bus.wb_valid_out), 32'(m_wb_v));
         if (m_wb_v) begin
            chk("wb_tag", 32'(bus.wb_rob_ix_out), m_wb_tag);
            chk("wb_data", bus.wb_data_out, m_wb_data);
         end
      end
   end

   task automatic cyc();
      @(posedge clk_in);
      #1;
   endtask

   task automatic alloc(input int tag, input logic [31:0] addr);
      bus.alloc_valid_in  = 1'b1;
      bus.alloc_rob_ix_in = ROB_IX_W'(tag);
      bus.alloc_addr_in   = addr;
      cyc();
      bus.alloc_valid_in  = 1'b0;
   endtask

   task automatic respond(input int tag, input logic [31:0] data);
      bus.mem_resp_valid_in  = 1'b1;
      bus.mem_resp_rob_ix_in = ROB_IX_W'(tag);
      bus.mem_resp_data_in   = data;
      cyc();
      bus.mem_resp_valid_in  = 1'b0;
   endtask

   initial begin
      bus.flush_in = 0; bus.alloc_valid_in = 0; bus.alloc_addr_in = 0; bus.alloc_rob_ix_in = 0;
      bus.can_load_mask_in = 0; bus.mem_req_ready_in = 0;
      bus.mem_resp_valid_in = 0; bus.mem_resp_rob_ix_in = 0; bus.mem_resp_data_in = 0;
      repeat (2) cyc();
      rst_in = 1'b0;
      #1;
      chk("rst_occ", 32'(bus.occupancy_out), 0);
      chk("rst_ready", 32'(bus.alloc_ready_out), 1);
      chk("rst_req_valid", 32'(bus.mem_req_valid_out), 0);
      chk("rst_wb_valid", 32'(bus.wb_valid_out), 0);

      // Asynchronous reset in the middle of operation
      for (int k = 1; k <= 3; k++) alloc(k, 32'h100 + 32'(4*(k-1)));
      chk("pre_rst_occ", 32'(bus.occupancy_out), 3);
      #2 rst_in = 1'b1;
      #1;
      chk("async_rst_occ", 32'(bus.occupancy_out), 0);
      chk("async_rst_ready", 32'(bus.alloc_ready_out), 1);
      chk("async_rst_req", 32'(bus.mem_req_valid_out), 0);
      cyc();
      rst_in = 1'b0;
      cyc();

      // Fill, then overflow alloc
      for (int k = 1; k <= 4; k++) alloc(k, 32'h100 + 32'(4*(k-1)));
      #1 chk("full_ready", 32'(bus.alloc_ready_out), 0);
      alloc(5, 32'h200);
      #1 chk("full_occ", 32'(bus.occupancy_out), 4);

      bus.can_load_mask_in = 8'b0000_1000; bus.mem_req_ready_in = 1'b1;
      #1;
      chk("issue3_addr", bus.mem_req_addr_out, 32'h108);
      chk("issue3_tag", 32'(bus.mem_req_rob_ix_out), 3);
      cyc();
      bus.can_load_mask_in = 8'b0001_0010;
      repeat (2) cyc();
      bus.can_load_mask_in = 0; bus.mem_req_ready_in = 1'b0;

      respond(4, 32'hDEADBEEF);
      #1;
      chk("wb4_valid", 32'(bus.wb_valid_out), 1);
      chk("wb4_tag", 32'(bus.wb_rob_ix_out), 4);
      chk("wb4_data", bus.wb_data_out, 32'hDEADBEEF);
      chk("wb4_occ", 32'(bus.occupancy_out), 3);
      cyc();
      chk("wb4_pulse", 32'(bus.wb_valid_out), 0);

      // Back-pressure holds the WAIT entry
      bus.can_load_mask_in = 8'b0000_0100;
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk("stall_req_valid", 32'(bus.mem_req_valid_out), 1);
         chk("stall_req_tag", 32'(bus.mem_req_rob_ix_out), 2);
         chk("stall_wb", 32'(bus.wb_valid_out), 0);
      end
      bus.can_load_mask_in = 0;
      respond(7, 32'h77777777);
      #1;
      chk("unknown_wb", 32'(bus.wb_valid_out), 0);
      chk("unknown_occ", 32'(bus.occupancy_out), 3);

      // Free entry 0, refill with tag 6, race it against tag 2
      respond(1, 32'h11111111);
      alloc(6, 32'h300);
      bus.can_load_mask_in = 8'b0100_0100; bus.mem_req_ready_in = 1'b1;
      #1;
`ifdef LQ_OLDEST_FIRST_EN
      chk("order_tag", 32'(bus.mem_req_rob_ix_out), 2);
      chk("order_addr", bus.mem_req_addr_out, 32'h104);
`else
      chk("order_tag", 32'(bus.mem_req_rob_ix_out), 6);
      chk("order_addr", bus.mem_req_addr_out, 32'h300);
`endif
      cyc();
      bus.can_load_mask_in = 0; bus.mem_req_ready_in = 1'b0;

      // Flush with 2 ISSUED + 1 WAIT, colliding response and alloc dropped
      bus.flush_in = 1'b1;
      bus.alloc_valid_in = 1'b1; bus.alloc_rob_ix_in = 3'd7; bus.alloc_addr_in = 32'h400;
      respond(3, 32'h33333333);
      bus.flush_in = 1'b0; bus.alloc_valid_in = 1'b0;
      #1;
      chk("flush_occ", 32'(bus.occupancy_out), 0);
      chk("flush_wb", 32'(bus.wb_valid_out), 0);
      chk("flush_ready", 32'(bus.alloc_ready_out), 1);
      cyc();

      // Normal round trip after flush
      alloc(1, 32'h500);
      bus.can_load_mask_in = 8'b0000_0010; bus.mem_req_ready_in = 1'b1;
      cyc();
      bus.can_load_mask_in = 0; bus.mem_req_ready_in = 1'b0;
      respond(1, 32'hCAFEF00D);
      #1;
      chk("post_wb_data", bus.wb_data_out, 32'hCAFEF00D);
      repeat (3) cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
